spi_slave_param: RTL

Parametrised SPI slave, next generation of the team's fixed 8-bit mode-0 slave. It adds configurable word width, all four CPOL/CPHA modes and MSB/LSB-first order. A valid/ready transmit holding register supports back-to-back multi-word frames, and the block reports underruns. It sits between an external SPI master and on-chip logic; all SPI pins are oversampled in the clk domain.

---
 rtl/spi_slave_param.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/spi_slave_param.sv
// Parametrised SPI slave: configurable word width, CPOL/CPHA mode and bit order, with a
// valid/ready transmit holding register. All SPI pins are oversampled in the clk domain.
module spi_slave_param #(
    parameter int unsigned       DATA_W    = 8,
    parameter int unsigned       CPOL      = 0,
    parameter int unsigned       CPHA      = 0,
    parameter int unsigned       MSB_FIRST = 1,
    parameter logic [DATA_W-1:0] IDLE_WORD = '0
) (
    input  logic              clk,
    input  logic              ar,
    input  logic              sck,
    input  logic              cs,
    input  logic              mosi,
    output logic              miso,
    output logic              miso_oe,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              tx_underrun,
    output logic              frame_end
);

    localparam int unsigned CTR_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CTR_W-1:0] LAST_BIT = CTR_W'(DATA_W - 1);

    typedef enum logic {StIdle, StActive} state_e;

    state_e            state_q, state_d;
    logic [2:0]        sck_q;
    logic [2:0]        cs_q;
    logic [1:0]        mosi_q;
    logic [CTR_W-1:0]  bit_ctr_q, bit_ctr_d;
    logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              rx_done_q, rx_done_d;
    logic              rx_valid_q, rx_valid_d;
    logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic              hold_full_q, hold_full_d;
    logic              underrun_q, underrun_d;
    logic              frame_end_q, frame_end_d;

    logic sck_rise, sck_fall, cs_rise, cs_fall;
    logic lead_edge, trail_edge, sample_edge, shift_edge;
    logic mosi_sync, load;

    // Synchronisers clear to zero; a CS already low at reset release is not an edge, so the
    // block waits for a fresh falling edge.
    always_ff @(posedge clk or negedge ar) begin
        if (!ar) begin
            sck_q  <= '0;
            cs_q   <= '0;
            mosi_q <= '0;
        end else begin
            sck_q  <= {sck_q[1:0], sck};
            cs_q   <= {cs_q[1:0], cs};
            mosi_q <= {mosi_q[0], mosi};
        end
    end

    assign sck_rise  = sck_q[1] & ~sck_q[2];
    assign sck_fall  = ~sck_q[1] & sck_q[2];
    assign cs_rise   = cs_q[1] & ~cs_q[2];
    assign cs_fall   = ~cs_q[1] & cs_q[2];
    assign mosi_sync = mosi_q[1];

    assign lead_edge   = (CPOL != 0) ? sck_fall : sck_rise;
    assign trail_edge  = (CPOL != 0) ? sck_rise : sck_fall;
    assign sample_edge = (CPHA != 0) ? trail_edge : lead_edge;
    assign shift_edge  = (CPHA != 0) ? lead_edge : trail_edge;

    always_comb begin
        state_d     = state_q;
        bit_ctr_d   = bit_ctr_q;
        rx_shift_d  = rx_shift_q;
        rx_data_d   = rx_data_q;
        rx_done_d   = 1'b0;
        rx_valid_d  = 1'b0;
        tx_shift_d  = tx_shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        underrun_d  = 1'b0;
        frame_end_d = 1'b0;
        load        = 1'b0;

        // Word completed on the previous cycle; publish it even if CS has since risen.
        if (rx_done_q) begin
            rx_data_d  = rx_shift_q;
            rx_valid_d = 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                bit_ctr_d  = '0;
                rx_shift_d = '0;
                if (cs_fall) begin
                    state_d    = StActive;
                    tx_shift_d = '0;
                    load       = (CPHA == 0);
                end
            end
            StActive: begin
                if (cs_rise) begin
                    // Partial words are dropped; the holding register is left alone.
                    state_d     = StIdle;
                    frame_end_d = 1'b1;
                    bit_ctr_d   = '0;
                    rx_shift_d  = '0;
                    tx_shift_d  = '0;
                end else begin
                    if (sample_edge) begin
                        if (MSB_FIRST != 0) begin
                            rx_shift_d = {rx_shift_q[DATA_W-2:0], mosi_sync};
                        end else begin
                            rx_shift_d = {mosi_sync, rx_shift_q[DATA_W-1:1]};
                        end
                        if (bit_ctr_q == LAST_BIT) begin
                            bit_ctr_d = '0;
                            rx_done_d = 1'b1;
                        end else begin
                            bit_ctr_d = bit_ctr_q + 1'b1;
                        end
                    end
                    // A shift edge at bit 0 is a word boundary in both phases.
                    if (shift_edge) begin
                        if (bit_ctr_q == '0) begin
                            load = 1'b1;
                        end else if (MSB_FIRST != 0) begin
                            tx_shift_d = {tx_shift_q[DATA_W-2:0], 1'b0};
                        end else begin
                            tx_shift_d = {1'b0, tx_shift_q[DATA_W-1:1]};
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (load) begin
            if (hold_full_q) begin
                tx_shift_d  = hold_q;
                hold_full_d = 1'b0;
            end else begin
                tx_shift_d = IDLE_WORD;
                underrun_d = 1'b1;
            end
        end

        // Accept only when empty, so this never collides with a load of a full register.
        if (tx_valid && !hold_full_q) begin
            hold_d      = tx_data;
            hold_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge ar) begin
        if (!ar) begin
            state_q     <= StIdle;
            bit_ctr_q   <= '0;
            rx_shift_q  <= '0;
            rx_data_q   <= '0;
            rx_done_q   <= 1'b0;
            rx_valid_q  <= 1'b0;
            tx_shift_q  <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            underrun_q  <= 1'b0;
            frame_end_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_ctr_q   <= bit_ctr_d;
            rx_shift_q  <= rx_shift_d;
            rx_data_q   <= rx_data_d;
            rx_done_q   <= rx_done_d;
            rx_valid_q  <= rx_valid_d;
            tx_shift_q  <= tx_shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            underrun_q  <= underrun_d;
            frame_end_q <= frame_end_d;
        end
    end

    assign miso        = (state_q == StActive) &&
                         ((MSB_FIRST != 0) ? tx_shift_q[DATA_W-1] : tx_shift_q[0]);
    assign miso_oe     = (state_q == StActive);
    assign tx_ready    = ~hold_full_q;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign tx_underrun = underrun_q;
    assign frame_end   = frame_end_q;

endmodule
